// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time programmable clock divider controller.
// Sequences start, stop and divisor changes so that clkout only changes on
// half-period boundaries. A new divisor arrives over a valid/ready handshake.
// Optional feature macro: CLKDIV_CTRL_EDGECNT_EN adds edge_cnt[15:0], a count
// of clkout rising edges that is cleared on every IDLE->RUN transition.
module clkdiv_ctrl #(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clkout,
    output logic             tick,
    output logic             busy
`ifdef CLKDIV_CTRL_EDGECNT_EN
    ,
    output logic [15:0]      edge_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, SWITCH, STOP} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] counter_reg, counter_next;
    logic [WIDTH-1:0] div_active_reg, div_active_next;
    logic [WIDTH-1:0] div_pending_reg, div_pending_next;
    logic             pend_reg, pend_next;
    logic             clkout_reg, clkout_next;
    logic             tick_reg, tick_next;

    logic             xfer;
    logic             tc;
    logic [WIDTH-1:0] cfg_div_fixed;

    // Handshake, terminal count and zero-divisor substitution
    always_comb begin
        cfg_ready     = (state_reg == IDLE) || (state_reg == RUN);
        busy          = (state_reg != IDLE);
        xfer          = cfg_valid && cfg_ready;
        tc            = (counter_reg == div_active_reg - WIDTH'(1));
        cfg_div_fixed = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
    end

    // Next-state and datapath: counting always finishes the half-period in progress
    always_comb begin
        state_next       = state_reg;
        counter_next     = counter_reg;
        div_active_next  = div_active_reg;
        div_pending_next = div_pending_reg;
        pend_next        = pend_reg;
        clkout_next      = clkout_reg;
        tick_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                counter_next = '0;
                clkout_next  = 1'b0;
                // A transfer delays the start by one cycle so the new divisor is in place first
                if (xfer) begin
                    div_active_next = cfg_div_fixed;
                end else if (run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (tc) begin
                    counter_next = '0;
                    clkout_next  = ~clkout_reg;
                    tick_next    = 1'b1;
                end else begin
                    counter_next = counter_reg + WIDTH'(1);
                end
                if (xfer) begin
                    div_pending_next = cfg_div_fixed;
                    pend_next        = 1'b1;
                end
                if (!run) begin
                    state_next = STOP;
                end else if (xfer) begin
                    state_next = SWITCH;
                end
            end
            SWITCH: begin
                if (tc) begin
                    counter_next    = '0;
                    clkout_next     = ~clkout_reg;
                    tick_next       = 1'b1;
                    div_active_next = div_pending_reg;
                    pend_next       = 1'b0;
                    state_next      = run ? RUN : STOP;
                end else begin
                    counter_next = counter_reg + WIDTH'(1);
                    if (!run) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Low phase can be cut short safely; a high phase must run to its full length
                if (!clkout_reg) begin
                    counter_next = '0;
                    state_next   = IDLE;
                end else if (tc) begin
                    counter_next = '0;
                    clkout_next  = 1'b0;
                    tick_next    = 1'b1;
                    state_next   = IDLE;
                end else begin
                    counter_next = counter_reg + WIDTH'(1);
                end
                if ((state_next == IDLE) && pend_reg) begin
                    div_active_next = div_pending_reg;
                    pend_next       = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            counter_reg     <= '0;
            div_active_reg  <= WIDTH'(DEFAULT_DIV);
            div_pending_reg <= '0;
            pend_reg        <= 1'b0;
            clkout_reg      <= 1'b0;
            tick_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            counter_reg     <= counter_next;
            div_active_reg  <= div_active_next;
            div_pending_reg <= div_pending_next;
            pend_reg        <= pend_next;
            clkout_reg      <= clkout_next;
            tick_reg        <= tick_next;
        end
    end

    assign clkout = clkout_reg;
    assign tick   = tick_reg;

`ifdef CLKDIV_CTRL_EDGECNT_EN
    logic [15:0] edge_cnt_reg;

    // Rising-edge counter, restarted each time the divider starts from IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt_reg <= '0;
        end else if ((state_reg == IDLE) && (state_next == RUN)) begin
            edge_cnt_reg <= '0;
        end else if (!clkout_reg && clkout_next) begin
            edge_cnt_reg <= edge_cnt_reg + 16'd1;
        end
    end

    assign edge_cnt = edge_cnt_reg;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Testbench for clkdiv_ctrl: measures clk cycles between tick pulses against a
// queue of expected half-period lengths, plus hand sequences for stop, switch
// and asynchronous reset corner cases.
module tb_clkdiv_ctrl;

    localparam int W    = 8;
    localparam int DDIV = 4;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         run       = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div   = '0;
    logic         cfg_ready;
    logic         clkout;
    logic         tick;
    logic         busy;
`ifdef CLKDIV_CTRL_EDGECNT_EN
    logic [15:0]  edge_cnt;
`endif

    clkdiv_ctrl #(.WIDTH(W), .DEFAULT_DIV(DDIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clkout    (clkout),
        .tick      (tick),
        .busy      (busy)
`ifdef CLKDIV_CTRL_EDGECNT_EN
        ,
        .edge_cnt  (edge_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    typedef struct {
        int div;
        int first;
        int half;
        int nhalf;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Count negedges until tick is seen high; bounded
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 300);
    endtask

    // Pop each expected half-period and compare with the measured tick spacing
    task automatic drain(input string name);
        int e;
        int n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick(n);
            check(name, n, e);
        end
    endtask

    task automatic go_idle();
        run       = 1'b0;
        cfg_valid = 1'b0;
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        check("reach_idle", int'(busy), 0);
    endtask

    initial begin
        int n;

        vecs[0] = '{4, 5, 4, 3};
        vecs[1] = '{1, 2, 1, 4};
        vecs[2] = '{0, 2, 1, 4};
        vecs[3] = '{3, 4, 3, 3};
        vecs[4] = '{7, 8, 7, 2};

        // Reset defaults with run held high
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_clkout", int'(clkout), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        reset_n = 1'b1;
        wait_tick(n);
        check("rst_first_rise", n, DDIV + 1);
        check("rst_clkout_high", int'(clkout), 1);
`ifdef CLKDIV_CTRL_EDGECNT_EN
        check("edge_cnt_first", int'(edge_cnt), 1);
`endif
        exp_q.push_back(DDIV);
        exp_q.push_back(DDIV);
        drain("rst_half");

        // Divisor change mid-period: offer 2 at counter=1
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = W'(2);
        check("sw_ready_run", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("sw_ready_switch", int'(cfg_ready), 0);
        wait_tick(n);
        check("sw_old_half_rest", n, 2);
        check("sw_ready_back", int'(cfg_ready), 1);
        for (int k = 0; k < 3; k++) exp_q.push_back(2);
        drain("sw_new_half");

        // Table: program in IDLE, start, measure half-periods
        for (int i = 0; i < 5; i++) begin
            go_idle();
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_div   = W'(vecs[i].div);
            check("tbl_cfg_ready", int'(cfg_ready), 1);
            @(negedge clk);
            cfg_valid = 1'b0;
            run       = 1'b1;
            exp_q.push_back(vecs[i].first);
            for (int k = 0; k < vecs[i].nhalf; k++) exp_q.push_back(vecs[i].half);
            drain($sformatf("tbl%0d_div%0d", i, vecs[i].div));
        end

        // Clean stop while high, div=3
        go_idle();
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = W'(3);
        @(negedge clk);
        cfg_valid = 1'b0;
        run       = 1'b1;
        wait_tick(n);
        check("stop_hi_first", n, 4);
        check("stop_hi_clkout", int'(clkout), 1);
        run = 1'b0;
        wait_tick(n);
        check("stop_hi_tail", n, 3);
        check("stop_hi_fall", int'(clkout), 0);
        check("stop_hi_busy", int'(busy), 0);
        @(negedge clk);
        check("stop_hi_tick_once", int'(tick), 0);

        // Stop from SWITCH with pending=6 while clkout low
        @(negedge clk);
        run = 1'b1;
        wait_tick(n);
        check("pend_first", n, 4);
        wait_tick(n);
        check("pend_second", n, 3);
        check("pend_clkout_low", int'(clkout), 0);
        cfg_valid = 1'b1;
        cfg_div   = W'(6);
        check("pend_ready", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        run       = 1'b0;
        check("pend_in_switch", int'(cfg_ready), 0);
        @(negedge clk);
        check("pend_stop_busy", int'(busy), 1);
        @(negedge clk);
        check("pend_idle_busy", int'(busy), 0);
        check("pend_idle_clkout", int'(clkout), 0);
        run = 1'b1;
        exp_q.push_back(7);
        exp_q.push_back(6);
        exp_q.push_back(6);
        drain("pend_restart");

        // Asynchronous reset between edges while clkout high
        check("areset_pre_clkout", int'(clkout), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_clkout", int'(clkout), 0);
        check("areset_busy", int'(busy), 0);
        check("areset_tick", int'(tick), 0);
`ifdef CLKDIV_CTRL_EDGECNT_EN
        check("areset_edge_cnt", int'(edge_cnt), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        wait_tick(n);
        check("areset_default_div", n, DDIV + 1);
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
